// File: rtl/queue_ctrl_if.sv
// Handshake bundle for queue_ctrl.
//   Upstream byte channel : in_valid, in_data, in_ready
//   Downstream word channel: word_valid, word_ready, word_data, word_bytes
// Modports:
//   slave  - the controller side (accepts bytes, presents words)
//   master - the environment side (produces bytes, consumes words)
interface queue_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  word_valid;
  logic                  word_ready;
  logic [4*DATA_W-1:0]   word_data;
  logic [2:0]            word_bytes;

  modport slave (
    input  in_valid, in_data, word_ready,
    output in_ready, word_valid, word_data, word_bytes
  );

  modport master (
    output in_valid, in_data, word_ready,
    input  in_ready, word_valid, word_data, word_bytes
  );
endinterface

// File: rtl/queue_ctrl.sv
// Sequencing controller for a 4-stage byte shift queue.
// Accepts bytes on a valid/ready channel, drives the queue shift enable and
// data, tracks the fill level, and presents each completed 32-bit word to a
// consumer with backpressure. A partial word can be closed with pad bytes,
// either on an explicit flush or after an idle timeout.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous, active-low reset
//   bus     - queue_ctrl_if.slave: byte input channel and word output channel
//   flush   - close the current partial word (honoured only while filling)
//   q_en    - queue shift enable
//   q_data  - byte shifted into the queue
//   q_word  - queue parallel output, passed through as bus.word_data
//   busy    - a word is in progress or pending
module queue_ctrl #(
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  PAD     = {DATA_W{1'b0}},
  parameter int                 TIMEOUT = 16,
  parameter int                 TO_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  queue_ctrl_if.slave          bus,
  input  logic                 flush,
  output logic                 q_en,
  output logic [DATA_W-1:0]    q_data,
  input  logic [4*DATA_W-1:0]  q_word,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_FILL,
    S_PAD,
    S_FULL
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      cnt, cnt_nx;
  logic [2:0]      wb, wb_nx;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic [TO_W-1:0] to_inc;
  logic            to_fire;
  logic            in_rdy, q_en_i, wv;

  // The timeout acts as a flush in the idle cycle whose increment brings the
  // counter up to TIMEOUT, so PAD starts right after TIMEOUT idle cycles.
  assign to_inc  = to_cnt + 1'b1;
  assign to_fire = (TIMEOUT != 0) && (state == S_FILL) && (cnt != 2'd0) &&
                   !bus.in_valid && (to_inc == TO_W'(TIMEOUT));

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wb_nx    = wb;
    to_nx    = '0;
    in_rdy   = 1'b0;
    q_en_i   = 1'b0;
    q_data   = bus.in_data;
    wv       = 1'b0;

    case (state)
      S_FILL: begin
        in_rdy = 1'b1;
        q_en_i = bus.in_valid;
        if (bus.in_valid) begin
          // The byte is taken before any flush is considered.
          if (cnt == 2'd3) begin
            state_nx = S_FULL;
            cnt_nx   = 2'd0;
            wb_nx    = 3'd4;
          end else begin
            cnt_nx = cnt + 2'd1;
            if (flush) begin
              state_nx = S_PAD;
              wb_nx    = {1'b0, cnt} + 3'd1;
            end
          end
        end else if (cnt != 2'd0) begin
          if (flush || to_fire) begin
            state_nx = S_PAD;
            wb_nx    = {1'b0, cnt};
          end else begin
            to_nx = to_inc;
          end
        end
      end

      S_PAD: begin
        q_en_i = 1'b1;
        q_data = PAD;
        // cnt wraps 3 -> 0 on the last pad shift.
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) state_nx = S_FULL;
      end

      S_FULL: begin
        wv     = 1'b1;
        in_rdy = bus.word_ready;
        q_en_i = bus.word_ready & bus.in_valid;
        if (bus.word_ready) begin
          // The consumer samples q_word on the same edge the queue shifts,
          // so a byte can be accepted while the old word leaves.
          state_nx = S_FILL;
          cnt_nx   = bus.in_valid ? 2'd1 : 2'd0;
        end
      end

      default: begin
        state_nx = S_FILL;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_FILL;
      cnt    <= 2'd0;
      wb     <= 3'd0;
      to_cnt <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wb     <= wb_nx;
      to_cnt <= to_nx;
    end
  end

  // Handshake outputs are held low for as long as reset is asserted.
  assign bus.in_ready   = in_rdy & rst;
  assign q_en           = q_en_i & rst;
  assign bus.word_valid = wv & rst;
  assign bus.word_data  = q_word;
  assign bus.word_bytes = wb;
  assign busy           = (cnt != 2'd0) || (state != S_FILL);

endmodule

// File: tb/tb_queue_ctrl.sv
// Testbench for queue_ctrl: directed byte sequences, a behavioural 4-stage
// shift queue, and a scoreboard of expected words checked by a monitor.
module tb_queue_ctrl;

  localparam int DATA_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 q_en;
  logic [DATA_W-1:0]    q_data;
  logic [4*DATA_W-1:0]  q_word = '0;
  logic                 busy;

  queue_ctrl_if #(.DATA_W(DATA_W)) bus ();

  queue_ctrl #(
    .DATA_W (DATA_W),
    .PAD    (8'h00),
    .TIMEOUT(4),
    .TO_W   (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .flush (flush),
    .q_en  (q_en),
    .q_data(q_data),
    .q_word(q_word),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Queue model: newest byte enters at the least significant end.
  always @(posedge clk) begin
    if (q_en) q_word <= {q_word[3*DATA_W-1:0], q_data};
  end

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every word handed to the consumer is matched against the
  // oldest expected entry.
  always @(negedge clk) begin
    if (bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus.word_data);
      end else begin
        cur = sb.pop_front();
        check("word_data", bus.word_data, cur.data);
        check("word_bytes", 32'(bus.word_bytes), 32'(cur.bytes));
      end
    end
  end

  // One cycle: wait past the edge, drive inputs, let combinational outputs settle.
  task automatic drive(input logic r, input logic v, input logic [7:0] d,
                       input logic f, input logic wr);
    @(posedge clk);
    #1;
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    flush        = f;
    bus.word_ready = wr;
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] b);
    exp_t e;
    e.data  = d;
    e.bytes = b;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    flush = 1'b0;
    bus.word_ready = 1'b1;

    // Reset: handshake outputs forced low even with in_valid high.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_q_en", 32'(q_en), 0);
      check("rst_word_valid", 32'(bus.word_valid), 0);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("post_rst_word_bytes", 32'(bus.word_bytes), 0);
    check("post_rst_word_valid", 32'(bus.word_valid), 0);

    // Four back-to-back bytes, consumer always ready.
    begin
      logic [7:0] t1 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      push(32'hAABBCCDD, 3'd4);
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'b1, t1[i], 1'b0, 1'b1);
        check("t1_q_en", 32'(q_en), 1);
        check("t1_q_data", 32'(q_data), 32'(t1[i]));
        check("t1_word_valid", 32'(bus.word_valid), 0);
      end
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t1_full_valid", 32'(bus.word_valid), 1);
    check("t1_full_bytes", 32'(bus.word_bytes), 4);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_valid_after", 32'(bus.word_valid), 0);

    // Backpressure: word held for 5 cycles, then taken while byte 11 enters.
    begin
      logic [7:0] t2 [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
      push(32'h10203040, 3'd4);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, t2[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
      check("t2_hold_valid", 32'(bus.word_valid), 1);
      check("t2_hold_in_ready", 32'(bus.in_ready), 0);
      check("t2_hold_q_en", 32'(q_en), 0);
      check("t2_hold_data", bus.word_data, 32'h10203040);
    end
    push(32'h11223344, 3'd4);
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
    check("t2_take_in_ready", 32'(bus.in_ready), 1);
    check("t2_take_q_en", 32'(q_en), 1);
    check("t2_take_q_data", 32'(q_data), 32'h11);
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    check("t2_cnt1_busy", 32'(busy), 1);
    check("t2_cnt1_valid", 32'(bus.word_valid), 0);
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    check("t2_fill_valid", 32'(bus.word_valid), 0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t2_full_valid", 32'(bus.word_valid), 1);

    // Explicit flush after two bytes: two pad cycles, word_bytes=2.
    push(32'h01020000, 3'd2);
    drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h02, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("t3_flush_q_en", 32'(q_en), 0);
    for (int i = 0; i < 2; i++) begin
      // flush held in the first pad cycle must be discarded
      drive(1'b1, 1'b1, 8'h77, (i == 0), 1'b1);
      check("t3_pad_q_en", 32'(q_en), 1);
      check("t3_pad_q_data", 32'(q_data), 32'h00);
      check("t3_pad_in_ready", 32'(bus.in_ready), 0);
      check("t3_pad_busy", 32'(busy), 1);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_full_valid", 32'(bus.word_valid), 1);
    check("t3_full_bytes", 32'(bus.word_bytes), 2);

    // Idle timeout (4 cycles) after one byte: three pad cycles, word_bytes=1.
    push(32'h5A000000, 3'd1);
    drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      check("t4_idle_q_en", 32'(q_en), 0);
      check("t4_idle_in_ready", 32'(bus.in_ready), 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      check("t4_pad_q_en", 32'(q_en), 1);
      check("t4_pad_in_ready", 32'(bus.in_ready), 0);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_full_valid", 32'(bus.word_valid), 1);
    check("t4_full_bytes", 32'(bus.word_bytes), 1);
    // Flush with an empty word is ignored.
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("t4_empty_flush_busy", 32'(busy), 0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_empty_flush_busy2", 32'(busy), 0);
    check("t4_empty_flush_q_en", 32'(q_en), 0);
    check("t4_empty_flush_valid", 32'(bus.word_valid), 0);

    // Flush together with the third byte: one pad cycle, word_bytes=3.
    push(32'h61626300, 3'd3);
    drive(1'b1, 1'b1, 8'h61, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h62, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h63, 1'b1, 1'b1);
    check("t5_flush_accept_q_en", 32'(q_en), 1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_pad_q_en", 32'(q_en), 1);
    check("t5_pad_in_ready", 32'(bus.in_ready), 0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_full_valid", 32'(bus.word_valid), 1);
    check("t5_full_bytes", 32'(bus.word_bytes), 3);
    // Flush together with the fourth byte: straight to FULL.
    push(32'h71727374, 3'd4);
    drive(1'b1, 1'b1, 8'h71, 1'b0, 1'b1);
    check("t5_hold_bytes_in_fill", 32'(bus.word_bytes), 3);
    drive(1'b1, 1'b1, 8'h72, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h73, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h74, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_direct_full_valid", 32'(bus.word_valid), 1);
    check("t5_direct_full_bytes", 32'(bus.word_bytes), 4);

    // Reset during the first pad cycle discards the partial word.
    drive(1'b1, 1'b1, 8'h81, 1'b0, 1'b1);
    check("t6_bytes_held", 32'(bus.word_bytes), 4);
    drive(1'b1, 1'b1, 8'h82, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t6_rst_q_en", 32'(q_en), 0);
    check("t6_rst_in_ready", 32'(bus.in_ready), 0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t6_busy", 32'(busy), 0);
    check("t6_in_ready", 32'(bus.in_ready), 1);
    check("t6_word_valid", 32'(bus.word_valid), 0);
    check("t6_word_bytes", 32'(bus.word_bytes), 0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t6_q_en_idle", 32'(q_en), 0);
    check("t6_word_valid2", 32'(bus.word_valid), 0);

    // Every expected word must have been delivered.
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
Sequencing controller for the 4-stage byte shift queue (8-bit in, 32-bit parallel out). It accepts bytes over a valid/ready handshake and drives the queue's shift enable and data. It counts fill level and presents the completed 32-bit word to a downstream consumer with valid/ready backpressure. It supports padding-based flush of partial words, requested explicitly or by an idle timeout.

Parameters:
DATA_W, 8, byte width fed to the queue
PAD, 8'h00, byte value injected during flush padding
TIMEOUT, 16, idle cycles with a partial word before auto-flush; 0 disables
TO_W, 5, timeout counter width; must hold TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  upstream byte valid
in_data  input  DATA_W  upstream byte
in_ready  output  1  controller can accept a byte this cycle
flush  input  1  request to close the current partial word; sampled only in FILL
q_en  output  1  queue shift enable
q_data  output  DATA_W  byte driven into queue
q_word  input  4*DATA_W  queue parallel output (Data_Q)
word_valid  output  1  completed word available
word_ready  input  1  consumer accepts word
word_data  output  4*DATA_W  equals q_word, combinational pass-through
word_bytes  output  3  number of real (non-pad) bytes in word, 1..4
busy  output  1  cnt != 0 or state != FILL

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst). rst low at a rising edge sets: state=FILL, cnt=0, word_bytes=0, timeout counter=0.
- While rst is low, in_ready, q_en and word_valid are forced 0 combinationally.
- States: FILL, PAD, FULL. cnt is 2 bits and holds the number of bytes shifted into the current word.
- Accept is defined as in_valid & in_ready.
- FILL:
  - in_ready=1, q_en=in_valid, q_data=in_data.
  - On accept: cnt+1. If cnt was 3, go to FULL with word_bytes=4 and cnt=0.
- Flush in FILL, triggered by flush=1 or timeout expiry:
  - cnt==0 with no accept: ignored.
  - No accept: go to PAD and latch word_bytes=cnt.
  - Accept in the same cycle: the byte is taken first. If the new count is 4, go to FULL with word_bytes=4. Otherwise go to PAD with word_bytes=cnt+1.
- PAD:
  - in_ready=0, q_en=1, q_data=PAD, cnt+1 each cycle.
  - When cnt==3, the last pad is shifted, then go to FULL with cnt=0.
  - Pad cycles = 4 - word_bytes.
- FULL:
  - word_valid=1; word_bytes and word_data are stable until the word is taken.
  - in_ready=word_ready, q_en=word_ready & in_valid.
  - On word_ready: go to FILL with cnt=1 if a byte was accepted that same cycle, else cnt=0. The consumer samples the old q_word at the same edge the queue shifts.
  - Without word_ready: everything holds, with no limit on duration.
- Latency: word_valid rises one cycle after the 4th byte is accepted, or one cycle after the last pad cycle.
- Timeout:
  - Counter increments each cycle in FILL with cnt>0 and no accept; clears on accept or on leaving FILL.
  - When it reaches TIMEOUT it acts as flush for that cycle. TIMEOUT=0 means the counter never fires.
- flush asserted in PAD or FULL is discarded, not queued.
- word_bytes is 0 after reset and holds its last value while in FILL.
- Reset mid-operation (PAD or FULL) discards the partial or pending word. The queue contents are not cleared by the controller.

Test Plan:
- Reset, then bytes AA,BB,CC,DD on 4 consecutive cycles with word_ready=1 -> q_en high 4 cycles with q_data AA..DD; word_valid=1 on cycle 5 with word_bytes=4; busy=0 after word taken.
- Fill 4 bytes, hold word_ready=0 for 5 cycles with in_valid=1 -> word_valid held, in_ready=0, q_en=0, word_data unchanged. Raise word_ready with in_valid=1, byte 11 -> word taken, 11 shifted, cnt=1.
- Bytes 01,02 then flush=1 for 1 cycle -> 2 PAD cycles (q_en=1, q_data=00, in_ready=0), then word_valid=1 with word_bytes=2.
- TIMEOUT=4, one byte 5A then idle -> after 4 idle cycles PAD starts (3 pad cycles), then word_bytes=1. flush at cnt=0 -> no PAD, busy stays 0.
- Third byte accepted in the same cycle as flush -> 1 PAD cycle, word_bytes=3. Fourth byte with flush -> FULL directly, word_bytes=4, no PAD.
- rst=0 during PAD cycle 1 -> next cycle state FILL, cnt=0, word_valid=0, in_ready=1 once rst=1.
